// File: rtl/seq010_tx.sv
// Serial frame transmitter for the 0-1-0 sync line: preamble 010, MSB-first data
// with a stuffed '1' after every "01" pair, then a "11" guard. Line idles high.
module seq010_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         tx,
  output logic                         busy,
  output logic                         frame_done,
  output logic [$clog2(DATA_W+1)-1:0]  stuff_cnt
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_STUFF,
    S_GUARD
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [1:0]        idx_q, idx_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              prev_q, prev_d;
  logic [CW-1:0]     stuff_cnt_q, stuff_cnt_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              bit_end;
  logic [1:0]        hist;
  logic [DATA_W-1:0] shift_n;

  // History of the last two line bits: the previous completed bit and the bit on the line now.
  assign hist    = {prev_q, tx_q};
  assign bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign shift_n = shift_q << 1;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    prev_d      = prev_q;
    stuff_cnt_d = stuff_cnt_q;
    tx_d        = tx_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (state_q != S_IDLE) begin
      timer_d = bit_end ? '0 : timer_q + TW'(1);
      if (bit_end) prev_d = tx_q;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid && ready_q) begin
          state_d     = S_PRE;
          shift_d     = in_data;
          stuff_cnt_d = '0;
          idx_d       = '0;
          bit_cnt_d   = '0;
          timer_d     = '0;
          tx_d        = 1'b0;
          ready_d     = 1'b0;
          busy_d      = 1'b1;
        end
      end
      S_PRE: begin
        if (bit_end) begin
          if (idx_q == 2'd2) begin
            state_d = S_DATA;
            tx_d    = shift_q[DATA_W-1];
          end else begin
            idx_d = idx_q + 2'd1;
            tx_d  = (idx_q == 2'd0);
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d   = shift_n;
          bit_cnt_d = bit_cnt_q + CW'(1);
          // The guard's leading '1' already breaks a trailing "01", so no stuff after the last bit.
          if (bit_cnt_q == CW'(DATA_W - 1)) begin
            state_d = S_GUARD;
            idx_d   = '0;
            tx_d    = 1'b1;
          end else if (hist == 2'b01) begin
            state_d     = S_STUFF;
            stuff_cnt_d = stuff_cnt_q + CW'(1);
            tx_d        = 1'b1;
          end else begin
            tx_d = shift_n[DATA_W-1];
          end
        end
      end
      S_STUFF: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[DATA_W-1];
        end
      end
      S_GUARD: begin
        if (bit_end) begin
          if (idx_q[0]) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            idx_d = 2'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q     <= S_IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      prev_q      <= 1'b1;
      stuff_cnt_q <= '0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      prev_q      <= prev_d;
      stuff_cnt_q <= stuff_cnt_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready   = ready_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign stuff_cnt  = stuff_cnt_q;

endmodule

// File: tb/tb_seq010_tx.sv
// Self-checking bench for seq010_tx: a reference frame builder fills a scoreboard queue,
// each cycle's line state is popped and compared; a 0-1-0 Moore detector watches the line.
module tb_seq010_tx;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst1, rst4;
  logic [W-1:0]  d1, d4;
  logic          v1, v4;
  logic          rdy1, rdy4, tx1, tx4, busy1, busy4, fd1, fd4;
  logic [CW-1:0] sc1, sc4;

  seq010_tx #(.DATA_W(W), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst1), .in_data(d1), .in_valid(v1), .in_ready(rdy1),
    .tx(tx1), .busy(busy1), .frame_done(fd1), .stuff_cnt(sc1)
  );

  seq010_tx #(.DATA_W(W), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst4), .in_data(d4), .in_valid(v4), .in_ready(rdy4),
    .tx(tx4), .busy(busy4), .frame_done(fd4), .stuff_cnt(sc4)
  );

  typedef struct packed {
    logic          tx;
    logic          fd;
    logic          rdy;
    logic [CW-1:0] sc;
    logic          chk_sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference Moore 0-1-0 detector on the CLKS_PER_BIT=1 line.
  int         fires1 = 0;
  logic [1:0] det1   = 2'b11;
  always @(posedge clk) begin
    if ({det1, tx1} === 3'b010) fires1++;
    det1 <= {det1[0], tx1};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Builds the expected line for one frame from the protocol rules, then the frame_done idle cycle.
  function automatic void push_frame(input logic [W-1:0] d, input int cpb);
    logic     bits[$];
    logic [1:0] h;
    int       s;
    exp_t     e;
    h = 2'b11;
    s = 0;
    bits.push_back(1'b0); bits.push_back(1'b1); bits.push_back(1'b0);
    h = 2'b10;
    for (int i = W - 1; i >= 0; i--) begin
      bits.push_back(d[i]);
      h = {h[0], d[i]};
      if (i > 0 && h == 2'b01) begin
        bits.push_back(1'b1);
        h = 2'b11;
        s++;
      end
    end
    bits.push_back(1'b1); bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int c = 0; c < cpb; c++) begin
        e = '{tx: bits[k], fd: 1'b0, rdy: 1'b0, sc: '0, chk_sc: 1'b0};
        exp_q.push_back(e);
      end
    end
    e = '{tx: 1'b1, fd: 1'b1, rdy: 1'b1, sc: CW'(s), chk_sc: 1'b1};
    exp_q.push_back(e);
  endfunction

  task automatic pop_check(input bit sel, input string tag, input int idx);
    exp_t e;
    check($sformatf("%s[%0d] queue", tag, idx), 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    if (!sel) begin
      check($sformatf("%s[%0d] tx", tag, idx), 32'(tx1), 32'(e.tx));
      check($sformatf("%s[%0d] frame_done", tag, idx), 32'(fd1), 32'(e.fd));
      check($sformatf("%s[%0d] in_ready", tag, idx), 32'(rdy1), 32'(e.rdy));
      check($sformatf("%s[%0d] busy", tag, idx), 32'(busy1), 32'(!e.rdy));
      if (e.chk_sc) check($sformatf("%s stuff_cnt", tag), 32'(sc1), 32'(e.sc));
    end else begin
      check($sformatf("%s[%0d] tx", tag, idx), 32'(tx4), 32'(e.tx));
      check($sformatf("%s[%0d] frame_done", tag, idx), 32'(fd4), 32'(e.fd));
      check($sformatf("%s[%0d] in_ready", tag, idx), 32'(rdy4), 32'(e.rdy));
      check($sformatf("%s[%0d] busy", tag, idx), 32'(busy4), 32'(!e.rdy));
      if (e.chk_sc) check($sformatf("%s stuff_cnt", tag), 32'(sc4), 32'(e.sc));
    end
  endtask

  task automatic set_in(input bit sel, input logic v, input logic [W-1:0] d);
    if (!sel) begin v1 = v; d1 = d; end
    else      begin v4 = v; d4 = d; end
  endtask

  // Drains the whole queue; data switches after the first accept, valid drops at drop_at.
  task automatic run(input bit sel, input string tag, input logic [W-1:0] d_after, input int drop_at);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0) set_in(sel, 1'b1, d_after);
      if (i == drop_at) set_in(sel, 1'b0, d_after);
      pop_check(sel, tag, i);
    end
  endtask

  task automatic check_idle(input bit sel, input string tag, input logic [CW-1:0] sc_exp);
    if (!sel) begin
      check({tag, " tx"}, 32'(tx1), 32'd1);
      check({tag, " in_ready"}, 32'(rdy1), 32'd1);
      check({tag, " busy"}, 32'(busy1), 32'd0);
      check({tag, " frame_done"}, 32'(fd1), 32'd0);
      check({tag, " stuff_cnt"}, 32'(sc1), 32'(sc_exp));
    end else begin
      check({tag, " tx"}, 32'(tx4), 32'd1);
      check({tag, " in_ready"}, 32'(rdy4), 32'd1);
      check({tag, " busy"}, 32'(busy4), 32'd0);
      check({tag, " frame_done"}, 32'(fd4), 32'd0);
      check({tag, " stuff_cnt"}, 32'(sc4), 32'(sc_exp));
    end
  endtask

  initial begin
    int f0;
    rst1 = 1'b1; rst4 = 1'b1;
    v1 = 1'b1; v4 = 1'b1;
    d1 = 8'hA5; d4 = 8'hA5;

    // Reset held two cycles with a word offered: nothing may start.
    for (int i = 0; i < 2; i++) begin
      step();
      check_idle(1'b0, $sformatf("rst1[%0d]", i), '0);
      check_idle(1'b1, $sformatf("rst4[%0d]", i), '0);
    end
    rst1 = 1'b0; rst4 = 1'b0;
    v1 = 1'b0; v4 = 1'b0;
    step();
    check_idle(1'b0, "post_rst1", '0);
    check_idle(1'b1, "post_rst4", '0);

    // All-zero payload: 13 line bits, no stuffing.
    f0 = fires1;
    set_in(1'b0, 1'b1, 8'h00);
    push_frame(8'h00, 1);
    run(1'b0, "f00", 8'h00, 0);
    check("f00 detector", 32'(fires1 - f0), 32'd1);

    // All-ones payload: one stuff after the first data bit.
    f0 = fires1;
    set_in(1'b0, 1'b1, 8'hFF);
    push_frame(8'hFF, 1);
    run(1'b0, "fFF", 8'hFF, 0);
    check("fFF detector", 32'(fires1 - f0), 32'd1);

    // Alternating payload: three stuffs, none after the final bit.
    f0 = fires1;
    set_in(1'b0, 1'b1, 8'h55);
    push_frame(8'h55, 1);
    run(1'b0, "f55", 8'h55, 0);
    check("f55 detector", 32'(fires1 - f0), 32'd1);
    step();
    check_idle(1'b0, "f55 hold", CW'(3));
    step();
    check_idle(1'b0, "f55 hold2", CW'(3));

    // Back-to-back: valid stays high, second accept lands in the frame_done cycle.
    f0 = fires1;
    set_in(1'b0, 1'b1, 8'h55);
    push_frame(8'h55, 1);
    push_frame(8'hAA, 1);
    run(1'b0, "b2b", 8'hAA, 17);
    check("b2b detector", 32'(fires1 - f0), 32'd2);

    // Slow line: each bit held four cycles, reset lands mid-frame.
    set_in(1'b1, 1'b1, 8'h80);
    push_frame(8'h80, 4);
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 0) set_in(1'b1, 1'b0, 8'h80);
      pop_check(1'b1, "c4_pre", i);
    end
    exp_q.delete();
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    check_idle(1'b1, "c4_abort", '0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle(1'b1, $sformatf("c4_quiet[%0d]", i), '0);
    end

    // Fresh frame after the abort runs to completion.
    set_in(1'b1, 1'b1, 8'h80);
    push_frame(8'h80, 4);
    run(1'b1, "c4", 8'h80, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
